multi_channel_accumulator: RTL
==============================

Name: multi_channel_accumulator

Overview:
Parametrised, registered successor to the onboarding combinational adder. It performs add, subtract, per-channel accumulate and clear on two unsigned operands. Each operation is accepted through a valid/ready handshake and produces one registered result with overflow/error flags. It sits between the tile's input pins and the output pins/SPI readback and holds CHANNELS independent running sums.

Parameters:
WIDTH, 8, operand width in bits (a, b)
ACC_WIDTH, 12, accumulator/result width; must be >= WIDTH+1
CHANNELS, 4, number of independent accumulators (1..16)
SATURATE, 1, 1 = clamp on overflow/underflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request this cycle
op  in  2  00 ADD a+b, 01 SUB a-b, 10 ACC acc[chan]+a+b, 11 CLR acc[chan]
chan  in  4  channel select (used by ACC/CLR, echoed for all ops)
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer accepts the result
result  out  ACC_WIDTH  operation result
out_chan  out  4  chan of the transfer that produced result
overflow  out  1  result exceeded range (clamped or wrapped)
err  out  1  chan >= CHANNELS on ACC/CLR

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-high (rst).
- Reset: out_valid=0, result=0, out_chan=0, overflow=0, err=0, all acc[*]=0. in_ready=1 one combinational step after reset deasserts.
- Asserting rst mid-operation discards any pending result and all accumulator contents immediately.
- in_ready = !out_valid || out_ready (combinational; one-deep output register, no bubble on back-to-back).
- Transfer occurs when in_valid && in_ready at a rising clk. result/flags/out_chan update on that edge, so latency is 1 cycle. out_valid=1 from the next cycle.
- If out_valid && !out_ready, result, out_chan, overflow and err hold stable. in_ready=0 and inputs are ignored.
- If out_valid && out_ready with no new transfer, out_valid clears at the next edge.
- Simultaneous consume and new transfer: out_valid stays 1 and the register loads the new result.
- Arithmetic is unsigned, computed at ACC_WIDTH+1 bits internally.
  - ADD: result = a+b zero-extended. overflow=0 (guaranteed by ACC_WIDTH >= WIDTH+1).
  - SUB: if a >= b, result = a-b and overflow=0. Otherwise overflow=1 and result = 0 (SATURATE=1) or (a-b) mod 2^ACC_WIDTH (SATURATE=0).
  - ACC: s = acc[chan]+a+b. If s > 2^ACC_WIDTH-1, overflow=1 and the value becomes 2^ACC_WIDTH-1 (SATURATE=1) or s mod 2^ACC_WIDTH (SATURATE=0). acc[chan] and result both take the post-clamp/wrap value.
  - CLR: acc[chan] = 0, result = 0, overflow = 0.
- ADD/SUB never read or modify accumulators.
- err: for ACC/CLR with chan >= CHANNELS, the transfer is still accepted. err=1, result=0, overflow=0, and no accumulator changes. For ADD/SUB err=0 regardless of chan.
- Flags are per-result: they describe the current result register only and are not sticky.
- A same-channel ACC on consecutive transfers uses the updated sum (accumulator write at the accept edge, no hazard).

Test Plan:
- Reset then ADD a=200 b=100 with out_ready=1 -> next cycle out_valid=1, result=300, overflow=0. out_valid drops the cycle after with no new request.
- SUB a=5 b=9 with SATURATE=1 -> result=0, overflow=1. With SATURATE=0 -> result=4092, overflow=1. SUB a=9 b=5 -> result=4, overflow=0.
- ACC chan=2 with a=255 b=255, nine back-to-back transfers, out_ready=1:
  - results 510, 1020, ..., 4080, then 4095 with overflow=1 (SATURATE=1); acc[2]=4095.
  - With SATURATE=0 the ninth result is 494 with overflow=1.
  - acc[0], acc[1] and acc[3] remain 0.
- Backpressure: out_ready=0 after an ADD 1+2 -> in_ready=0, result=3 held 5 cycles while new inputs toggle. Then out_ready=1 with a pending ADD 4+4 -> result=8 on the next edge with no idle cycle.
- ACC chan=7 (CHANNELS=4) a=10 b=10 -> err=1, result=0, accumulators unchanged. Then CLR chan=1 after ACC chan=1 3+4 -> results 7, then 0; acc[1]=0.
- Assert rst for one cycle while out_valid=1 and acc[2]=4095, asynchronously mid-cycle -> out_valid=0 and result=0 immediately. A subsequent ACC chan=2 1+1 returns 2.

Source files
------------

// File: rtl/multi_channel_accumulator.sv
// ---------------------------------------------------------------------------
// multi_channel_accumulator
//
// Registered add / subtract / per-channel accumulate / clear unit sitting
// between the tile input pins and the output pins / SPI readback. Each
// request is taken over a valid/ready handshake and yields exactly one
// registered result with overflow and error flags, one cycle later.
//
// Parameters
//   WIDTH      operand width (a, b)
//   ACC_WIDTH  accumulator / result width, must be >= WIDTH+1
//   CHANNELS   number of independent running sums (1..16)
//   SATURATE   1: clamp on overflow/underflow, 0: wrap modulo 2^ACC_WIDTH
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake
//   op                   00 ADD, 01 SUB, 10 ACC, 11 CLR
//   chan                 channel for ACC/CLR, echoed on out_chan for all ops
//   a, b                 unsigned operands
//   out_valid/out_ready  result handshake (one-deep output register)
//   result, out_chan     registered result and the channel that produced it
//   overflow             result was clamped or wrapped
//   err                  ACC/CLR addressed a channel >= CHANNELS
// ---------------------------------------------------------------------------
module multi_channel_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12,
    parameter int CHANNELS  = 4,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [3:0]           chan,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic [3:0]           out_chan,
    output logic                 overflow,
    output logic                 err
);

    // One guard bit above the result width catches both the ACC carry-out
    // and the SUB borrow.
    localparam int XW = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    op_t                  w_op;
    logic                 w_accept;
    logic                 w_chan_ok;
    logic                 w_acc_op;
    logic                 w_acc_we;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [XW-1:0]        w_diff;
    logic [XW-1:0]        w_acc_sum;
    logic [ACC_WIDTH-1:0] w_res;
    logic                 w_ovf;
    logic                 w_err;
    logic [ACC_WIDTH-1:0] w_acc_slot [16];

    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_result;
    logic [3:0]           r_out_chan;
    logic                 r_overflow;
    logic                 r_err;

    assign w_op      = op_t'(op);
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_chan_ok = ({1'b0, chan} < 5'(CHANNELS));
    assign w_acc_we  = w_accept && w_acc_op;

    assign w_sum     = ACC_WIDTH'(a) + ACC_WIDTH'(b);
    assign w_diff    = XW'(a) - XW'(b);
    // Slots beyond CHANNELS read as zero; they are only selected on the
    // err path, where the sum is discarded anyway.
    assign w_acc_sum = XW'(w_acc_slot[chan]) + XW'(a) + XW'(b);

    always_comb begin
        w_res    = '0;
        w_ovf    = 1'b0;
        w_err    = 1'b0;
        w_acc_op = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum;
            end
            OP_SUB: begin
                w_res = w_diff[ACC_WIDTH-1:0];
                // Top bit set means a < b (borrow out of the extended width).
                if (w_diff[XW-1]) begin
                    w_ovf = 1'b1;
                    if (SATURATE != 0) begin
                        w_res = '0;
                    end
                end
            end
            OP_ACC: begin
                if (!w_chan_ok) begin
                    w_err = 1'b1;
                end else begin
                    w_acc_op = 1'b1;
                    w_res    = w_acc_sum[ACC_WIDTH-1:0];
                    if (w_acc_sum[XW-1]) begin
                        w_ovf = 1'b1;
                        if (SATURATE != 0) begin
                            w_res = ACC_MAX;
                        end
                    end
                end
            end
            OP_CLR: begin
                if (!w_chan_ok) begin
                    w_err = 1'b1;
                end else begin
                    // w_res stays zero, which is also the cleared sum.
                    w_acc_op = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Per-channel running sums. The accumulator takes exactly the value
    // that goes to the result register, so a same-channel ACC on the next
    // transfer already sees the updated sum.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_chan
            if (gi < CHANNELS) begin : g_acc
                logic [ACC_WIDTH-1:0] r_acc;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_acc <= '0;
                    end else if (w_acc_we && (chan == 4'(gi))) begin
                        r_acc <= w_res;
                    end
                end
                assign w_acc_slot[gi] = r_acc;
            end else begin : g_none
                assign w_acc_slot[gi] = '0;
            end
        end
    endgenerate

    // One-deep output register: loads on every accepted transfer (including
    // the same edge a previous result is consumed), drops valid when the
    // result is consumed without a replacement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_chan  <= '0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_out_chan  <= chan;
            r_overflow  <= w_ovf;
            r_err       <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_chan  = r_out_chan;
    assign overflow  = r_overflow;
    assign err       = r_err;

endmodule
